// File: rtl/barrier_sync_pkg.sv
// barrier_sync_pkg: shared types and constants for the barrier synchroniser
package barrier_sync_pkg;
    localparam int PKG_BAR_ID_W = 16;
    localparam int PKG_BLK_ID_W = 10;
    localparam int PKG_WARPS    = 32;

    typedef enum logic [1:0] {ST_FREE, ST_COLLECTING, ST_PENDING} entry_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MASK    = 2'b01;
    localparam logic [1:0] ERR_DUP     = 2'b10;
    localparam logic [1:0] ERR_NOT_EXP = 2'b11;

    typedef struct packed {
        logic [PKG_BAR_ID_W-1:0] bar_id;
        logic [PKG_BLK_ID_W-1:0] blk_id;
        logic [PKG_WARPS-1:0]    warp_mask;
        logic                    timeout;
    } rel_rec_t;
endpackage

// File: rtl/barrier_sync_if.sv
// barrier_sync_if: arrival, release, error, statistics and debug signals of the barrier synchroniser
interface barrier_sync_if #(
    parameter int NUM_ENTRIES      = 16,
    parameter int WARPS_PER_BLOCK  = 32,
    parameter int THREADS_PER_WARP = 32,
    parameter int BAR_ID_W         = 16,
    parameter int BLK_ID_W         = 10
);
    localparam int WID_W = $clog2(WARPS_PER_BLOCK);
    localparam int IDX_W = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;

    logic                        arrive_valid;
    logic                        arrive_ready;
    logic [BAR_ID_W-1:0]         arrive_barrier_id;
    logic [BLK_ID_W-1:0]         arrive_block_id;
    logic [WID_W-1:0]            arrive_warp_id;
    logic [THREADS_PER_WARP-1:0] arrive_thread_mask;
    logic [WARPS_PER_BLOCK-1:0]  arrive_expected_mask;
    logic                        release_valid;
    logic                        release_ready;
    logic [BAR_ID_W-1:0]         release_barrier_id;
    logic [BLK_ID_W-1:0]         release_block_id;
    logic [WARPS_PER_BLOCK-1:0]  release_warp_mask;
    logic                        release_timeout;
    logic                        error_valid;
    logic [1:0]                  error_code;
    logic [31:0]                 barrier_count;
    logic [31:0]                 timeout_count;
    logic [31:0]                 stalled_cycle_count;
    logic [IDX_W-1:0]            dbg_entry;
    logic [WID_W-1:0]            dbg_warp;
    logic [THREADS_PER_WARP-1:0] dbg_thread_mask;

    modport slave (
        input  arrive_valid, arrive_barrier_id, arrive_block_id, arrive_warp_id,
               arrive_thread_mask, arrive_expected_mask, release_ready, dbg_entry, dbg_warp,
        output arrive_ready, release_valid, release_barrier_id, release_block_id,
               release_warp_mask, release_timeout, error_valid, error_code,
               barrier_count, timeout_count, stalled_cycle_count, dbg_thread_mask
    );

    modport master (
        output arrive_valid, arrive_barrier_id, arrive_block_id, arrive_warp_id,
               arrive_thread_mask, arrive_expected_mask, release_ready, dbg_entry, dbg_warp,
        input  arrive_ready, release_valid, release_barrier_id, release_block_id,
               release_warp_mask, release_timeout, error_valid, error_code,
               barrier_count, timeout_count, stalled_cycle_count, dbg_thread_mask
    );
endinterface

// File: rtl/barrier_release_fifo.sv
// barrier_release_fifo: synchronous FIFO of release records; head read straight from storage
module barrier_release_fifo
    import barrier_sync_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  rel_rec_t din,
    input  logic     pop,
    output rel_rec_t dout,
    output logic     valid,
    output logic     full
);
    localparam int AW = $clog2(DEPTH);

    rel_rec_t      mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;

    assign valid = wr_ptr != rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && valid) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/barrier_sync_unit.sv
// barrier_sync_unit: tracks concurrent (barrier, block) instances, watchdogs them and queues releases
module barrier_sync_unit
    import barrier_sync_pkg::*;
#(
    parameter int NUM_ENTRIES      = 16,
    parameter int WARPS_PER_BLOCK  = PKG_WARPS,
    parameter int THREADS_PER_WARP = 32,
    parameter int BAR_ID_W         = PKG_BAR_ID_W,
    parameter int BLK_ID_W         = PKG_BLK_ID_W,
    parameter int TIMEOUT_CYCLES   = 4096,
    parameter int REL_DEPTH        = 4
) (
    input logic           clk,
    input logic           rst_n,
    barrier_sync_if.slave bus
);
    localparam int WID_W = $clog2(WARPS_PER_BLOCK);
    localparam int IDX_W = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
    localparam int AGE_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES - 1);

    entry_state_t                st [NUM_ENTRIES];
    entry_state_t                st_nxt [NUM_ENTRIES];
    logic [BAR_ID_W-1:0]         bar_id [NUM_ENTRIES];
    logic [BLK_ID_W-1:0]         blk_id [NUM_ENTRIES];
    logic [WARPS_PER_BLOCK-1:0]  exp_mask [NUM_ENTRIES];
    logic [WARPS_PER_BLOCK-1:0]  arr_mask [NUM_ENTRIES];
    logic [THREADS_PER_WARP-1:0] thr_mask [NUM_ENTRIES][WARPS_PER_BLOCK];
    logic [AGE_W-1:0]            age [NUM_ENTRIES];
    logic                        tmo [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]      hit_v, free_v, pend_v, coll_v, wr_v, to_v;
    logic [IDX_W-1:0]            hit_idx, free_idx, pend_idx, tgt;
    logic [WID_W-1:0]            wid;
    logic [WARPS_PER_BLOCK-1:0]  new_arr;
    logic [1:0]                  err_code, code_q;
    logic                        hit, acc, upd, done, push, pop, full, rel_valid, err_q;
    logic [31:0]                 bar_cnt, tmo_cnt, stall_cnt;
    rel_rec_t                    rec_in, head;

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_ENTRIES-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

    always_comb begin
        hit_v  = '0;
        free_v = '0;
        pend_v = '0;
        coll_v = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            coll_v[e] = st[e] == ST_COLLECTING;
            free_v[e] = st[e] == ST_FREE;
            pend_v[e] = st[e] == ST_PENDING;
            hit_v[e]  = coll_v[e] && bar_id[e] == bus.arrive_barrier_id && blk_id[e] == bus.arrive_block_id;
        end
    end

    assign hit      = |hit_v;
    assign hit_idx  = lowest(hit_v);
    assign free_idx = lowest(free_v);
    assign pend_idx = lowest(pend_v);
    assign tgt      = hit ? hit_idx : free_idx;
    assign wid      = bus.arrive_warp_id;
    assign bus.arrive_ready = rst_n && (hit || (|free_v));
    assign acc      = bus.arrive_valid && bus.arrive_ready;
    // Check order matters: a mask mismatch hides duplicate and membership faults.
    assign err_code = (hit && exp_mask[hit_idx] != bus.arrive_expected_mask) ? ERR_MASK :
                      (hit && arr_mask[hit_idx][wid]) ? ERR_DUP :
                      !bus.arrive_expected_mask[wid] ? ERR_NOT_EXP : ERR_NONE;
    assign upd      = acc && err_code == ERR_NONE;
    assign new_arr  = (hit ? arr_mask[hit_idx] : '0) | (WARPS_PER_BLOCK'(1) << wid);
    assign done     = new_arr == bus.arrive_expected_mask;
    assign pop      = rel_valid && bus.release_ready;
    assign push     = (|pend_v) && (!full || pop);

    always_comb begin
        wr_v = '0;
        to_v = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            wr_v[e]   = upd && tgt == IDX_W'(e);
            to_v[e]   = TIMEOUT_CYCLES != 0 && coll_v[e] && age[e] == AGE_MAX && !wr_v[e];
            st_nxt[e] = (push && pend_idx == IDX_W'(e)) ? ST_FREE :
                        wr_v[e] ? (done ? ST_PENDING : ST_COLLECTING) :
                        to_v[e] ? ST_PENDING : st[e];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int e = 0; e < NUM_ENTRIES; e++) st[e] <= ST_FREE;
        else for (int e = 0; e < NUM_ENTRIES; e++) st[e] <= st_nxt[e];
    end

    // Entry payload is only meaningful outside FREE, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (wr_v[e]) begin
                if (!hit) begin
                    bar_id[e]   <= bus.arrive_barrier_id;
                    blk_id[e]   <= bus.arrive_block_id;
                    exp_mask[e] <= bus.arrive_expected_mask;
                    age[e]      <= '0;
                end else if (age[e] != AGE_MAX) age[e] <= age[e] + 1'b1;
                arr_mask[e]      <= new_arr;
                thr_mask[e][wid] <= bus.arrive_thread_mask;
                tmo[e]           <= 1'b0;
            end else if (to_v[e]) tmo[e] <= 1'b1;
            else if (coll_v[e]) age[e] <= age[e] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
            bar_cnt   <= '0;
            tmo_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            err_q     <= acc && err_code != ERR_NONE;
            code_q    <= acc ? err_code : ERR_NONE;
            bar_cnt   <= bar_cnt + 32'(pop);
            tmo_cnt   <= tmo_cnt + 32'(pop && head.timeout);
            stall_cnt <= stall_cnt + 32'(|coll_v);
        end
    end

    assign rec_in = '{bar_id: bar_id[pend_idx], blk_id: blk_id[pend_idx],
                      warp_mask: arr_mask[pend_idx], timeout: tmo[pend_idx]};

    barrier_release_fifo #(.DEPTH(REL_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .din(rec_in), .pop(pop),
        .dout(head), .valid(rel_valid), .full(full)
    );

    assign bus.release_valid       = rel_valid;
    assign bus.release_barrier_id  = head.bar_id;
    assign bus.release_block_id    = head.blk_id;
    assign bus.release_warp_mask   = head.warp_mask;
    assign bus.release_timeout     = head.timeout;
    assign bus.error_valid         = err_q;
    assign bus.error_code          = code_q;
    assign bus.barrier_count       = bar_cnt;
    assign bus.timeout_count       = tmo_cnt;
    assign bus.stalled_cycle_count = stall_cnt;
    assign bus.dbg_thread_mask     = thr_mask[bus.dbg_entry][bus.dbg_warp];
endmodule
